// File: rtl/mem_host_loader.sv
// Host word-stream loader in front of the memory unit.
// Decodes a one-word header, then assembles IMEM/DMEM records or loads the CR.
module mem_host_loader #(
  parameter int ROM_ADDRESS_WIDTH  = 16,
  parameter int DATA_ADDRESS_WIDTH = 16,
  parameter int INSTRUCTION_WIDTH  = 64,
  parameter int DATA_ROW_WIDTH     = 96
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [31:0]                   iWord,
  input  logic                          iWordValid,
  output logic                          oWordReady,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oError,
  output logic                          oInstructionWriteEnable,
  output logic [ROM_ADDRESS_WIDTH-1:0]  oInstructionWriteAddress,
  output logic [INSTRUCTION_WIDTH-1:0]  oInstruction,
  output logic                          oDataWriteEnable,
  output logic [DATA_ADDRESS_WIDTH-1:0] oDataWriteAddress,
  output logic [DATA_ROW_WIDTH-1:0]     oData,
  output logic [15:0]                   oControlRegister
);

  localparam int IWORDS = INSTRUCTION_WIDTH / 32;
  localparam int DWORDS = DATA_ROW_WIDTH / 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DROP,
    S_DONE
  } state_t;

  state_t state;

  logic [1:0]  tgt;
  logic [13:0] cnt;
  logic [13:0] rc;
  logic [1:0]  wc;
  logic [14:0] dc;

  logic [ROM_ADDRESS_WIDTH-1:0]  ibase;
  logic [DATA_ADDRESS_WIDTH-1:0] dbase;
  logic [INSTRUCTION_WIDTH-1:0]  ins_asm;
  logic [DATA_ROW_WIDTH-1:0]     dat_asm;

  logic                          xfer;
  logic [ROM_ADDRESS_WIDTH-1:0]  hdr_ibase;
  logic [DATA_ADDRESS_WIDTH-1:0] hdr_dbase;
  logic [INSTRUCTION_WIDTH-1:0]  ins_nxt;
  logic [DATA_ROW_WIDTH-1:0]     dat_nxt;
  logic hd_cr, hd_rsv, hd_bad, hd_zero, hd_load;
  logic rec_last;

  assign xfer      = iWordValid && oWordReady;
  assign hdr_ibase = ROM_ADDRESS_WIDTH'(iWord[15:0]);
  assign hdr_dbase = DATA_ADDRESS_WIDTH'(iWord[15:0]);

  // IMEM fills from the top so the first word ends up low;
  // DMEM fills from the bottom so the first word ends up high.
  assign ins_nxt = {iWord, ins_asm[INSTRUCTION_WIDTH-1:32]};
  assign dat_nxt = {dat_asm[DATA_ROW_WIDTH-33:0], iWord};

  assign hd_cr   = iWord[31:30] == 2'b10;
  assign hd_rsv  = iWord[31:30] == 2'b11;
  assign hd_bad  = iWord[31:30] == 2'b00
                && !hdr_ibase[ROM_ADDRESS_WIDTH-1];
  assign hd_zero = !iWord[31] && !hd_bad
                && iWord[29:16] == 14'd0;
  assign hd_load = !iWord[31] && !hd_bad
                && iWord[29:16] != 14'd0;

  assign rec_last = (tgt == 2'b00)
                  ? (wc == 2'(IWORDS - 1))
                  : (wc == 2'(DWORDS - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state                    <= S_IDLE;
      tgt                      <= '0;
      cnt                      <= '0;
      rc                       <= '0;
      wc                       <= '0;
      dc                       <= '0;
      ibase                    <= '0;
      dbase                    <= '0;
      ins_asm                  <= '0;
      dat_asm                  <= '0;
      oWordReady               <= 1'b0;
      oBusy                    <= 1'b0;
      oDone                    <= 1'b0;
      oError                   <= 1'b0;
      oInstructionWriteEnable  <= 1'b0;
      oInstructionWriteAddress <= '0;
      oInstruction             <= '0;
      oDataWriteEnable         <= 1'b0;
      oDataWriteAddress        <= '0;
      oData                    <= '0;
      oControlRegister         <= '0;
    end else begin
      oInstructionWriteEnable <= 1'b0;
      oDataWriteEnable        <= 1'b0;
      oDone                   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          oWordReady <= 1'b1;
          if (xfer) begin
            oError <= 1'b0;
            oBusy  <= 1'b1;
            tgt    <= iWord[31:30];
            cnt    <= iWord[29:16];
            ibase  <= hdr_ibase;
            dbase  <= hdr_dbase;
            rc     <= '0;
            wc     <= '0;
            dc     <= '0;
            unique case (1'b1)
              hd_cr: begin
                oControlRegister <= iWord[15:0];
                state            <= S_DONE;
                oWordReady       <= 1'b0;
                oDone            <= 1'b1;
              end
              hd_rsv: begin
                oError     <= 1'b1;
                state      <= S_DONE;
                oWordReady <= 1'b0;
                oDone      <= 1'b1;
              end
              hd_bad: begin
                oError <= 1'b1;
                if (iWord[29:16] == 14'd0) begin
                  state      <= S_DONE;
                  oWordReady <= 1'b0;
                  oDone      <= 1'b1;
                end else begin
                  state <= S_DROP;
                end
              end
              hd_zero: begin
                state      <= S_DONE;
                oWordReady <= 1'b0;
                oDone      <= 1'b1;
              end
              hd_load: state <= S_LOAD;
              default: state <= S_IDLE;
            endcase
          end
        end
        S_LOAD: begin
          if (xfer) begin
            wc      <= wc + 2'd1;
            ins_asm <= ins_nxt;
            dat_asm <= dat_nxt;
            if (rec_last) begin
              state      <= S_WRITE;
              oWordReady <= 1'b0;
              if (tgt == 2'b00) begin
                oInstructionWriteEnable  <= 1'b1;
                oInstructionWriteAddress <= ibase
                  + ROM_ADDRESS_WIDTH'(rc);
                oInstruction             <= ins_nxt;
              end else begin
                oDataWriteEnable  <= 1'b1;
                oDataWriteAddress <= dbase
                  + DATA_ADDRESS_WIDTH'(rc);
                oData             <= dat_nxt;
              end
            end
          end
        end
        S_WRITE: begin
          rc <= rc + 14'd1;
          wc <= '0;
          if (rc + 14'd1 == cnt) begin
            state <= S_DONE;
            oDone <= 1'b1;
          end else begin
            state      <= S_LOAD;
            oWordReady <= 1'b1;
          end
        end
        S_DROP: begin
          if (xfer) begin
            dc <= dc + 15'd1;
            if (dc + 15'd1 == {cnt, 1'b0}) begin
              state      <= S_DONE;
              oWordReady <= 1'b0;
              oDone      <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          oWordReady <= 1'b1;
          oBusy      <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          oWordReady <= 1'b1;
          oBusy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_host_loader.sv
// Scoreboard bench for mem_host_loader: directed plan plus random commands.
// A reference model predicts writes and completions; a monitor compares them.
module tb_mem_host_loader;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic [31:0]  iWord = '0;
  logic         iWordValid = 1'b0;
  logic         oWordReady, oBusy, oDone, oError;
  logic         oInstructionWriteEnable;
  logic [15:0]  oInstructionWriteAddress;
  logic [63:0]  oInstruction;
  logic         oDataWriteEnable;
  logic [15:0]  oDataWriteAddress;
  logic [95:0]  oData;
  logic [15:0]  oControlRegister;

  always #5 Clock = ~Clock;

  mem_host_loader dut (
    .Clock                    (Clock),
    .Reset                    (Reset),
    .iWord                    (iWord),
    .iWordValid               (iWordValid),
    .oWordReady               (oWordReady),
    .oBusy                    (oBusy),
    .oDone                    (oDone),
    .oError                   (oError),
    .oInstructionWriteEnable  (oInstructionWriteEnable),
    .oInstructionWriteAddress (oInstructionWriteAddress),
    .oInstruction             (oInstruction),
    .oDataWriteEnable         (oDataWriteEnable),
    .oDataWriteAddress        (oDataWriteAddress),
    .oData                    (oData),
    .oControlRegister         (oControlRegister)
  );

  // kind: 0 = IMEM write, 1 = DMEM write, 2 = command done
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [95:0] data;
    logic        err;
    logic [15:0] cr;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          errs = 0;
  int          checks = 0;
  logic [15:0] cr_m = '0;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference model: expected events of one command from header + payload.
  task automatic model(input logic [31:0] h, input logic [31:0] w[$]);
    logic [1:0]  t = h[31:30];
    int          c = int'(h[29:16]);
    logic [15:0] b = h[15:0];
    ev_t         e;
    logic        err = 1'b0;
    if (t == 2'b10) cr_m = b;
    if (t == 2'b11) err = 1'b1;
    if (t == 2'b00 && !b[15]) err = 1'b1;
    if (t == 2'b00 && b[15]) begin
      for (int r = 0; r < c; r++) begin
        e = '{kind: 0, addr: b + 16'(r),
              data: {32'h0, w[2*r+1], w[2*r]}, err: 1'b0, cr: 16'h0};
        exp_q.push_back(e);
      end
    end
    if (t == 2'b01) begin
      for (int r = 0; r < c; r++) begin
        e = '{kind: 1, addr: b + 16'(r),
              data: {w[3*r], w[3*r+1], w[3*r+2]}, err: 1'b0, cr: 16'h0};
        exp_q.push_back(e);
      end
    end
    e = '{kind: 2, addr: 16'h0, data: 96'h0, err: err, cr: cr_m};
    exp_q.push_back(e);
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      if (oInstructionWriteEnable && oDataWriteEnable)
        check("dual_strobe", 1, 0);
      if (oInstructionWriteEnable || oDataWriteEnable || oDone) begin
        check("ready_low", oWordReady, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_event",
                {oInstructionWriteEnable, oDataWriteEnable, oDone}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          case (mon_e.kind)
            0: begin
              check("imem_strobe",
                    {oInstructionWriteEnable, oDataWriteEnable, oDone},
                    3'b100);
              check("imem_addr", oInstructionWriteAddress, mon_e.addr);
              check("imem_data", oInstruction, mon_e.data[63:0]);
            end
            1: begin
              check("dmem_strobe",
                    {oInstructionWriteEnable, oDataWriteEnable, oDone},
                    3'b010);
              check("dmem_addr", oDataWriteAddress, mon_e.addr);
              check("dmem_data", oData, mon_e.data);
            end
            default: begin
              check("done_strobe",
                    {oInstructionWriteEnable, oDataWriteEnable, oDone},
                    3'b001);
              check("done_error", oError, mon_e.err);
              check("done_cr", oControlRegister, mon_e.cr);
              check("done_busy", oBusy, 1);
            end
          endcase
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input logic [31:0] w, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(1, 2)) @(negedge Clock);
    iWord      = w;
    iWordValid = 1'b1;
    while (!oWordReady && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (!oWordReady) begin
      check("ready_timeout", 0, 1);
      iWordValid = 1'b0;
      return;
    end
    @(negedge Clock);
    iWordValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge Clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("event_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge Clock);
  endtask

  task automatic run_cmd(input logic [31:0] h, input logic [31:0] w[$],
                         input bit gaps);
    model(h, w);
    send(h, gaps);
    foreach (w[i]) send(w[i], gaps);
    wait_idle();
  endtask

  function automatic int nwords(input logic [31:0] h);
    if (h[31:30] == 2'b00) return 2 * int'(h[29:16]);
    if (h[31:30] == 2'b01) return 3 * int'(h[29:16]);
    return 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"},
          {oWordReady, oBusy, oDone, oError, oInstructionWriteEnable,
           oDataWriteEnable, oInstructionWriteAddress, oDataWriteAddress,
           oControlRegister}, 0);
    check({tag, "_data"}, {oInstruction, oData}, 0);
  endtask

  task automatic release_reset();
    @(negedge Clock);
    Reset = 1'b1;
    cr_m  = '0;
    @(negedge Clock);
    check("ready_after_reset", {oWordReady, oBusy}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    logic [31:0] h;
    int          r;
    repeat (3) @(negedge Clock);
    check_reset_outputs("reset");
    release_reset();

    w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    run_cmd(32'h0002_8010, w, 1'b0);

    w = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    run_cmd(32'h4001_0005, w, 1'b1);

    w = {};
    run_cmd(32'h8000_00F3, w, 1'b0);
    check("cr_loaded", oControlRegister, 16'h00F3);
    Reset = 1'b0;
    #1;
    check("cr_reset", oControlRegister, 16'h0000);
    release_reset();

    w = '{32'hDEAD_0001, 32'hDEAD_0002};
    run_cmd(32'h0001_0010, w, 1'b0);
    w = {};
    run_cmd(32'hC000_0000, w, 1'b0);
    check("error_sticky", oError, 1);

    w = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303,
          32'h0404_0404, 32'h0505_0505, 32'h0606_0606};
    run_cmd(32'h4002_FFFF, w, 1'b0);
    check("error_cleared", oError, 0);
    w = {};
    run_cmd(32'h4000_0123, w, 1'b0);
    run_cmd(32'h0000_9000, w, 1'b0);

    // Reset in the middle of a DMEM record: nothing may be written.
    send(32'h4001_0007, 1'b0);
    send(32'h5555_5555, 1'b0);
    Reset      = 1'b0;
    iWordValid = 1'b0;
    #1;
    check_reset_outputs("midrec");
    repeat (2) @(negedge Clock);
    release_reset();
    w = '{32'h7777_0001, 32'h7777_0002, 32'h7777_0003};
    run_cmd(32'h4001_0009, w, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      h = $urandom;
      h[29:16] = 14'($urandom_range(0, 4));
      if (r < 4) begin
        h[31:30] = 2'b00;
        h[15]    = 1'b1;
      end else if (r < 7) begin
        h[31:30] = 2'b01;
      end else if (r == 7) begin
        h[31:30] = 2'b10;
      end else if (r == 8) begin
        h[31:30] = 2'b11;
      end else begin
        h[31:30] = 2'b00;
        h[15]    = 1'b0;
      end
      w = {};
      for (int i = 0; i < nwords(h); i++) w.push_back($urandom);
      run_cmd(h, w, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_host_loader.md
Name: mem_host_loader

Overview:
- Upstream feeder of the memory unit.
- Accepts a 32-bit host word stream over a valid/ready handshake and decodes a one-word command header.
- Assembles payload words into full instructions (IMEM) or data rows (DMEM), or loads the control register.
- Drives the memory unit's instruction-write, data-write and control-register inputs with registered, single-cycle write strobes.

Parameters:
- ROM_ADDRESS_WIDTH, 16, instruction address width; MSB=1 selects writable IMEM.
- DATA_ADDRESS_WIDTH, 16, DMEM address width.
- INSTRUCTION_WIDTH, 64, instruction width (2 host words).
- DATA_ROW_WIDTH, 96, data row width (3 host words).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iWord  in  32  host word.
- iWordValid  in  1  iWord valid.
- oWordReady  out  1  loader accepts iWord this cycle.
- oBusy  out  1  command in progress (state != IDLE).
- oDone  out  1  one-cycle pulse at command completion.
- oError  out  1  sticky error flag; cleared on next accepted header.
- oInstructionWriteEnable  out  1  IMEM write strobe.
- oInstructionWriteAddress  out  ROM_ADDRESS_WIDTH  IMEM write address.
- oInstruction  out  INSTRUCTION_WIDTH  IMEM write data.
- oDataWriteEnable  out  1  DMEM write strobe.
- oDataWriteAddress  out  DATA_ADDRESS_WIDTH  DMEM write address.
- oData  out  DATA_ROW_WIDTH  DMEM write data.
- oControlRegister  out  16  control register value to the memory unit.

Behaviour:
- Transfer occurs when iWordValid && oWordReady at a rising edge.
- Header word fields:
  - [31:30] target: 00 IMEM, 01 DMEM, 10 CR, 11 reserved.
  - [29:16] count: number of records.
  - [15:0] base: zero-extended or truncated to the address width.
- Record sizes: IMEM 2 words, low word first → [31:0] then [63:32]. DMEM 3 words, first word → [95:64], then [63:32], then [31:0].
- Reset (Reset=0, asynchronous): state IDLE; all outputs 0, including oWordReady, all write strobes and oControlRegister. The first cycle after release has oWordReady=1.
- States:
  - IDLE: ready=1. On header transfer, clear oError, latch target, count and base, zero the record counter (rc) and word counter (wc). Next state:
    - CR → DONE; oControlRegister <= header[15:0], count ignored.
    - Reserved target → DONE; oError <= 1.
    - IMEM with base MSB=0 → DROP; oError <= 1.
    - count=0 → DONE.
    - Otherwise → LOAD.
  - LOAD: ready=1. Each transfer shifts the word into the assembly register and increments wc. The last word of a record (wc = 1 for IMEM, 2 for DMEM) → WRITE.
  - WRITE: ready=0 for exactly one cycle.
    - The matching strobe is 1, address = base + rc (modulo 2^width; wraps silently), data = assembled record.
    - rc++, wc=0.
    - Next state: rc+1 == count → DONE, else → LOAD.
  - DROP: ready=1. Consumes and discards count×2 words, with no strobes. After the last word → DONE.
  - DONE: ready=0, oDone=1 for one cycle → IDLE.
- Strobes are high only in WRITE and never both high at once. Address and data outputs hold their last written values otherwise.
- A valid word while ready=0 is not consumed. The host must hold it stable (AXI-style; valid must not drop without a transfer).
- Minimum throughput: IMEM 1 record per 3 cycles, DMEM 1 record per 4 cycles.
- Reset mid-command: immediate return to IDLE and reset values. Partial records are never written.
- oControlRegister changes only on a CR header or on reset.

Test Plan:
- IMEM load: header 0x0002_8010 (IMEM, count 2, base 0x8010), then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 → two strobes: addr 0x8010 data 0x22222222_11111111, addr 0x8011 data 0x44444444_33333333. Then oDone pulses once; oError stays 0.
- DMEM load with gaps: header 0x4001_0005, then words A, B, C with iWordValid low between them → one strobe at addr 0x0005 with data {A,B,C}. oWordReady is 0 during the WRITE and DONE cycles.
- CR load: header 0x8000_00F3 → oControlRegister=0x00F3 the next cycle, oDone pulses, no write strobes. Then reset → oControlRegister=0.
- Errors:
  - Header 0x0001_0010 (IMEM, base MSB=0) → oError=1, the next 2 words are consumed with no strobes, oDone pulses.
  - Header 0xC000_0000 → oError=1, oDone pulses.
  - A subsequent valid header clears oError.
- Wrap and zero count:
  - DMEM header base 0xFFFF, count 2 → writes at addresses 0xFFFF then 0x0000.
  - Header count 0 → oDone pulses with no strobes.
- Reset mid-record: assert Reset after 1 of 3 DMEM words → no strobe occurs, all outputs are 0, and a fresh header after release is decoded correctly.
